// File: rtl/partition_pkg.sv
// Shared definitions for the partition error accumulator: FSM state
// encoding, default widths and the sweep length implied by the default
// input width.
package partition_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_OUT_W = 4;
  localparam int unsigned DEF_HD_W  = 3;
  localparam int unsigned DEF_ACC_W = 11;

  // Number of samples in one exhaustive sweep of a DEF_IN_W-bit partition.
  localparam int unsigned SWEEP_LEN = 1 << DEF_IN_W;

endpackage

// File: rtl/partition_popcount.sv
// Combinational population count of an OUT_W-bit vector into HD_W bits.
// Used for the per-sample Hamming distance and the per-bit error hits.
module partition_popcount
  import partition_pkg::*;
#(
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned HD_W  = DEF_HD_W
) (
  input  logic [OUT_W-1:0] vec_i,
  output logic [HD_W-1:0]  cnt_o
);

  // Sum the set bits; HD_W is wide enough that the count never wraps.
  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < OUT_W; k++) begin
      cnt_o = cnt_o + HD_W'(vec_i[k]);
    end
  end

endmodule

// File: rtl/partition_err_accum.sv
// Partition error accumulator: consumes (index, exact, approx) samples of
// an exhaustive sweep and accumulates total Hamming distance, mismatch
// count and maximum Hamming distance, flagging out-of-order samples.
// Optional per-output-bit error counters: define PARTITION_ERR_BITPOS_EN.
module partition_err_accum
  import partition_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned HD_W  = DEF_HD_W,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_idx,
  input  logic [OUT_W-1:0]  s_exact,
  input  logic [OUT_W-1:0]  s_approx,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  hd_sum,
  output logic [IN_W:0]     mis_cnt,
  output logic [HD_W-1:0]   hd_max,
  output logic              seq_err
`ifdef PARTITION_ERR_BITPOS_EN
  ,
  output logic [OUT_W*(IN_W+1)-1:0] bit_err_cnt
`endif
);

  // Index of the final sample of a sweep; its accept ends the run.
  localparam logic [IN_W:0] LAST_IDX = {1'b0, {IN_W{1'b1}}};

  state_e               state_q, state_d;
  logic [ACC_W-1:0]     hd_sum_q, hd_sum_d;
  logic [IN_W:0]        mis_cnt_q, mis_cnt_d;
  logic [HD_W-1:0]      hd_max_q, hd_max_d;
  logic                 seq_err_q, seq_err_d;
  logic [IN_W:0]        exp_idx_q, exp_idx_d;

  logic [OUT_W-1:0]     diff;
  logic [HD_W-1:0]      hd;
  logic                 accept;
  logic                 clear;

  assign diff   = s_exact ^ s_approx;
  assign accept = s_valid && (state_q == RUN);
  // start only has effect outside RUN; a pulse mid-sweep is ignored.
  assign clear  = start && (state_q != RUN);

  partition_popcount #(
    .OUT_W (OUT_W),
    .HD_W  (HD_W)
  ) u_hd (
    .vec_i (diff),
    .cnt_o (hd)
  );

  // Next-state and state-decoded handshake/status outputs.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (accept && (exp_idx_q == LAST_IDX)) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Metric update: clear on a sweep start, accumulate on each accept.
  always_comb begin
    hd_sum_d  = hd_sum_q;
    mis_cnt_d = mis_cnt_q;
    hd_max_d  = hd_max_q;
    seq_err_d = seq_err_q;
    exp_idx_d = exp_idx_q;
    if (clear) begin
      hd_sum_d  = '0;
      mis_cnt_d = '0;
      hd_max_d  = '0;
      seq_err_d = 1'b0;
      exp_idx_d = '0;
    end else if (accept) begin
      hd_sum_d  = hd_sum_q + ACC_W'(hd);
      mis_cnt_d = mis_cnt_q + (IN_W+1)'(hd != '0);
      if (hd > hd_max_q) hd_max_d = hd;
      // An out-of-order sample is flagged but still accumulated.
      if ({1'b0, s_idx} != exp_idx_q) seq_err_d = 1'b1;
      exp_idx_d = exp_idx_q + (IN_W+1)'(1);
    end
  end

  // State and metric registers; reset wipes any partial result.
  // NOTE: sequential state is assigned with <= so every register samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hd_sum_q  <= '0;
      mis_cnt_q <= '0;
      hd_max_q  <= '0;
      seq_err_q <= 1'b0;
      exp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      hd_sum_q  <= hd_sum_d;
      mis_cnt_q <= mis_cnt_d;
      hd_max_q  <= hd_max_d;
      seq_err_q <= seq_err_d;
      exp_idx_q <= exp_idx_d;
    end
  end

  assign hd_sum  = hd_sum_q;
  assign mis_cnt = mis_cnt_q;
  assign hd_max  = hd_max_q;
  assign seq_err = seq_err_q;

`ifdef PARTITION_ERR_BITPOS_EN
  logic [OUT_W*(IN_W+1)-1:0] bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0]          bit_hit;

  for (genvar k = 0; k < OUT_W; k++) begin : g_bit
    partition_popcount #(
      .OUT_W (1),
      .HD_W  (1)
    ) u_bit (
      .vec_i (diff[k]),
      .cnt_o (bit_hit[k])
    );
  end

  // Per-bit error counters follow the same clear/accept rules as mis_cnt.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      bit_cnt_d = '0;
    end else if (accept) begin
      for (int k = 0; k < OUT_W; k++) begin
        bit_cnt_d[k*(IN_W+1) +: (IN_W+1)] =
          bit_cnt_q[k*(IN_W+1) +: (IN_W+1)] + (IN_W+1)'(bit_hit[k]);
      end
    end
  end

  // Per-bit counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_cnt_q <= '0;
    else        bit_cnt_q <= bit_cnt_d;
  end

  assign bit_err_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_partition_err_accum.sv
// Self-checking bench for partition_err_accum (default widths). Drives
// whole sweeps from a table of traffic patterns and compares the DUT
// against a running reference model after every accepted sample, plus
// hand-written reset and DONE-state sequences.
module tb_partition_err_accum;
  import partition_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 4;
  localparam int HD_W  = 3;
  localparam int ACC_W = 11;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [IN_W-1:0]   s_idx;
  logic [OUT_W-1:0]  s_exact;
  logic [OUT_W-1:0]  s_approx;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  hd_sum;
  logic [IN_W:0]     mis_cnt;
  logic [HD_W-1:0]   hd_max;
  logic              seq_err;
`ifdef PARTITION_ERR_BITPOS_EN
  logic [OUT_W*(IN_W+1)-1:0] bit_err_cnt;
`endif

  partition_err_accum #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .HD_W  (HD_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_idx    (s_idx),
    .s_exact  (s_exact),
    .s_approx (s_approx),
    .busy     (busy),
    .done     (done),
    .hd_sum   (hd_sum),
    .mis_cnt  (mis_cnt),
    .hd_max   (hd_max),
    .seq_err  (seq_err)
`ifdef PARTITION_ERR_BITPOS_EN
    ,
    .bit_err_cnt (bit_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: metrics of the samples accepted so far.
  int m_sum;
  int m_mis;
  int m_max;
  bit m_seq;
  int m_bits[OUT_W];

  typedef struct {
    string name;
    int    mode;      // 0 clean, 1 bit0 error everywhere, 2 full error at idx 5, 3 random
    int    gap_pct;   // chance in percent of an idle cycle before each sample
    bit    swap;      // exchange idx 10 and 11
    bit    use_model; // final values come from the model instead of constants
    int    exp_sum;
    int    exp_mis;
    int    exp_max;
    bit    exp_seq;
  } case_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_busy"},    32'(busy),    0);
    check({tag, "_done"},    32'(done),    0);
    check({tag, "_hd_sum"},  32'(hd_sum),  0);
    check({tag, "_mis_cnt"}, 32'(mis_cnt), 0);
    check({tag, "_hd_max"},  32'(hd_max),  0);
    check({tag, "_seq_err"}, 32'(seq_err), 0);
`ifdef PARTITION_ERR_BITPOS_EN
    check({tag, "_bit_err_cnt"}, 32'(bit_err_cnt), 0);
`endif
  endtask

  // Called #1 after a rising edge; leaves the DUT in RUN.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
  endtask

  task automatic check_metrics(input string tag);
    check({tag, "_hd_sum"},  32'(hd_sum),  32'(m_sum));
    check({tag, "_mis_cnt"}, 32'(mis_cnt), 32'(m_mis));
    check({tag, "_hd_max"},  32'(hd_max),  32'(m_max));
    check({tag, "_seq_err"}, 32'(seq_err), 32'(m_seq));
`ifdef PARTITION_ERR_BITPOS_EN
    for (int k = 0; k < OUT_W; k++)
      check({tag, "_bit_slice"}, 32'(bit_err_cnt[k*(IN_W+1) +: (IN_W+1)]), 32'(m_bits[k]));
`endif
  endtask

  // Feed n samples of the given traffic pattern, checking after each accept.
  task automatic run_sweep(input int mode, input int gap_pct, input bit swap, input int n);
    logic [IN_W-1:0]  idx;
    logic [OUT_W-1:0] ex, ap;
    int               d;
    m_sum = 0; m_mis = 0; m_max = 0; m_seq = 1'b0;
    for (int k = 0; k < OUT_W; k++) m_bits[k] = 0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid  = 1'b0;
        s_idx    = IN_W'($urandom);
        s_exact  = OUT_W'($urandom);
        s_approx = OUT_W'($urandom);
        @(posedge clk); #1;
      end
      idx = IN_W'(i);
      if (swap && i == 10) idx = 8'd11;
      if (swap && i == 11) idx = 8'd10;
      if (mode == 3 && $urandom_range(0, 127) == 0) idx = IN_W'(i + 3);
      ex = OUT_W'($urandom);
      case (mode)
        1:       ap = ex ^ 4'b0001;
        2:       ap = (i == 5) ? (ex ^ 4'b1111) : ex;
        3:       ap = ($urandom_range(0, 3) == 0) ? (ex ^ OUT_W'($urandom)) : ex;
        default: ap = ex;
      endcase
      // A start pulse in RUN must be ignored.
      start    = (mode == 3 && i == 50);
      s_valid  = 1'b1;
      s_idx    = idx;
      s_exact  = ex;
      s_approx = ap;
      @(posedge clk); #1;
      start = 1'b0;
      d = $countones(ex ^ ap);
      m_sum += d;
      if (d != 0) m_mis++;
      if (d > m_max) m_max = d;
      if (int'(idx) != i) m_seq = 1'b1;
      for (int k = 0; k < OUT_W; k++) if (ex[k] != ap[k]) m_bits[k]++;
      check_metrics("acc");
      check("acc_done", 32'(done), 32'(i == int'(SWEEP_LEN) - 1));
    end
    s_valid = 1'b0;
  endtask

  // Valid traffic while in DONE must leave everything untouched.
  task automatic poke_done();
    for (int c = 0; c < 4; c++) begin
      s_valid  = 1'b1;
      s_idx    = IN_W'($urandom);
      s_exact  = OUT_W'($urandom);
      s_approx = ~s_exact;
      check("done_s_ready", 32'(s_ready), 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check_metrics("done_hold");
    check("done_hold_done", 32'(done), 1);
  endtask

  case_t tbl[6];

  initial begin
    tbl[0] = '{"clean",      0, 0,  1'b0, 1'b0, 0,   0,   0, 1'b0};
    tbl[1] = '{"single_bit", 1, 0,  1'b0, 1'b0, 256, 256, 1, 1'b0};
    tbl[2] = '{"full_idx5",  2, 0,  1'b0, 1'b0, 4,   1,   4, 1'b0};
    tbl[3] = '{"gaps",       1, 30, 1'b0, 1'b0, 256, 256, 1, 1'b0};
    tbl[4] = '{"swap",       1, 0,  1'b1, 1'b0, 256, 256, 1, 1'b1};
    tbl[5] = '{"random",     3, 20, 1'b0, 1'b1, 0,   0,   0, 1'b0};

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
    s_idx = '0; s_exact = '0; s_approx = '0;
    #12;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      do_start();
      run_sweep(tbl[t].mode, tbl[t].gap_pct, tbl[t].swap, int'(SWEEP_LEN));
      if (!tbl[t].use_model) begin
        check({tbl[t].name, "_sum"}, 32'(hd_sum),  32'(tbl[t].exp_sum));
        check({tbl[t].name, "_mis"}, 32'(mis_cnt), 32'(tbl[t].exp_mis));
        check({tbl[t].name, "_max"}, 32'(hd_max),  32'(tbl[t].exp_max));
        check({tbl[t].name, "_seq"}, 32'(seq_err), 32'(tbl[t].exp_seq));
      end
      check({tbl[t].name, "_done"}, 32'(done), 1);
      poke_done();
    end

    // Reset in the middle of a sweep clears everything at once.
    do_start();
    run_sweep(1, 0, 1'b0, 100);
    check("pre_reset_sum", 32'(hd_sum), 100);
    #1 rst_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    // Samples without a start are ignored in IDLE.
    for (int c = 0; c < 3; c++) begin
      s_valid = 1'b1; s_idx = IN_W'(c); s_exact = 4'h0; s_approx = 4'hF;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check_zero_outputs("idle_ignore");

    do_start();
    run_sweep(0, 0, 1'b0, int'(SWEEP_LEN));
    check("post_reset_sum",  32'(hd_sum),  0);
    check("post_reset_mis",  32'(mis_cnt), 0);
    check("post_reset_max",  32'(hd_max),  0);
    check("post_reset_seq",  32'(seq_err), 0);
    check("post_reset_done", 32'(done),    1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/partition_err_accum.md
Name: partition_err_accum

Overview:
- Response-side counterpart of the exhaustive partition testbenches.
- Those benches sweep every input vector of an approximated partition and emit one output word per vector. This block consumes that stream as (index, exact output, approximate output) samples and accumulates the error metrics used to score each partition: total Hamming distance, mismatch count and maximum Hamming distance.
- Sits after the stimulus sweeper, which is wired to the exact and approximate partition instances.
- Raises done once all 2^IN_W vectors have been accepted.

Parameters:
- IN_W, 8, partition input width; the sweep length is 2^IN_W samples.
- OUT_W, 4, partition output width.
- HD_W, 3, width of a per-sample Hamming distance; must satisfy 2^HD_W > OUT_W.
- ACC_W, 11, width of the Hamming-distance sum; must satisfy ACC_W >= IN_W + HD_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears results and begins a sweep.
- s_valid  in  1  sample valid.
- s_ready  out  1  block can accept a sample.
- s_idx  in  IN_W  input vector index of the sample.
- s_exact  in  OUT_W  exact partition output.
- s_approx  in  OUT_W  approximate partition output.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- hd_sum  out  ACC_W  sum of per-sample Hamming distances.
- mis_cnt  out  IN_W+1  number of samples with exact != approx.
- hd_max  out  HD_W  largest per-sample Hamming distance.
- seq_err  out  1  sticky; a sample arrived out of sweep order.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting rst_n low forces state to IDLE and drives s_ready, busy, done, hd_sum, mis_cnt, hd_max, seq_err and the internal expected-index counter to 0. This applies at any point, including mid-sweep. No partial result survives reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE: s_ready=0. On start, clear all results and the expected-index counter, then go to RUN on the next edge.
  - RUN: s_ready=1 and busy=1. A sample is accepted on any edge where s_valid && s_ready. Gaps in s_valid are allowed.
  - DONE: done=1, s_ready=0, results held. On start, clear and go to RUN, exactly as from IDLE.
  - start is ignored while in RUN.
- Per accepted sample:
  - hd = popcount(s_exact ^ s_approx), zero-extended to HD_W.
  - hd_sum += hd.
  - mis_cnt += (hd != 0).
  - hd_max = max(hd_max, hd).
  - If s_idx != expected index, set seq_err. The sample is still accumulated.
  - Expected index increments by 1. The counter is IN_W+1 bits wide, so it does not wrap inside a sweep.
- Latency: results reflect an accepted sample on the cycle after its accept edge.
- Completion: the accept of the 2^IN_W-th sample moves the FSM to DONE on that same edge. When done first reads 1, all results already include the last sample. No further samples are accepted.
- Overflow: cannot occur with legal parameters (maximum hd_sum = 2^IN_W * OUT_W). No saturation logic is required.
- s_valid while not in RUN: ignored, no side effects.

Optional Feature:
- Macro: PARTITION_ERR_BITPOS_EN.
- Defined:
  - Adds output bit_err_cnt, OUT_W*(IN_W+1) bits wide.
  - Slice k counts accepted samples where bit k of s_exact differs from bit k of s_approx.
  - Slices follow the same clear, update and latency rules as mis_cnt.
  - Invariant: the sum of all slices equals hd_sum.
- Undefined: the port and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package partition_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default widths IN_W=8, OUT_W=4, HD_W=3;
  - the sweep-length constant 2^IN_W.
- One sub-module, partition_popcount: combinational, OUT_W-bit input, HD_W-bit output. It is reused by the top and by the optional per-bit logic.

Test Plan:
- Clean sweep: start, then 256 back-to-back samples with idx 0..255 and approx == exact -> done after the 256th accept; hd_sum=0, mis_cnt=0, hd_max=0, seq_err=0.
- Single-bit error: approx = exact ^ 4'b0001 for every sample -> hd_sum=256, mis_cnt=256, hd_max=1. With PARTITION_ERR_BITPOS_EN, bit_err_cnt slice0=256 and other slices=0.
- Single full error: only idx 5 has approx = exact ^ 4'b1111 -> hd_sum=4, mis_cnt=1, hd_max=4.
- Backpressure and gaps: same traffic as the single-bit error case with random s_valid idles -> identical results; done does not assert before the 256th accept; s_valid in DONE changes nothing.
- Order check: swap idx 10 and 11 -> seq_err=1 from the cycle after the idx 11 sample is accepted; metrics are still correct.
- Reset mid-run: drop rst_n after 100 samples -> all outputs 0 and state IDLE immediately. A fresh start followed by a clean sweep gives clean results.
